// File: rtl/sc_rowshifter_pkg.sv
// sc_rowshifter_pkg
// Shared definitions for the LED-matrix row shifter and its neighbours
// (bottom-side comparators, game FSM). It holds the direction-FSM
// state encoding and the default row width, tick rate and start pattern,
// so every block that touches the row agrees on them.
package sc_rowshifter_pkg;

  // Direction FSM encoding. HOLD is all zeros so that "moving" is simply
  // the OR of the state bits.
  typedef enum logic [1:0] {
    HOLD  = 2'b00,
    LEFT  = 2'b01,
    RIGHT = 2'b10
  } rowState_t;

  localparam int              DEFAULT_DATAWIDTH   = 8;
  localparam int              DEFAULT_TICKDIV     = 25000000;
  localparam int              DEFAULT_TICKWIDTH   = 25;
  localparam logic [7:0]      DEFAULT_INITPATTERN = 8'b00000001;

endpackage

// File: rtl/sc_rowshifter_pong_tickprescaler.sv
// sc_tickprescaler
// Free-running game-tick prescaler. It counts 0..TICKDIV-1 and wraps,
// raising 'terminal' combinationally during the last count of each
// period. A synchronous clear restarts the period from zero.
// Ports:
//   clock    - rising-edge clock
//   reset    - synchronous active-high reset, count <= 0
//   clear    - synchronous restart of the period, count <= 0
//   terminal - high while count == TICKDIV-1
module sc_tickprescaler #(
  parameter int TICKDIV   = 25000000,
  parameter int TICKWIDTH = 25
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  output logic terminal
);

  logic [TICKWIDTH-1:0] count;

  // The compare is done at the counter width so that a wide TICKDIV
  // constant does not widen the comparator.
  assign terminal = (count == TICKWIDTH'(TICKDIV - 1));

  // Period counter: reset and clear both restart the period, otherwise
  // wrap to zero after the terminal count.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      count <= '0;
    end else if (terminal) begin
      count <= '0;
    end else begin
      count <= count + TICKWIDTH'(1);
    end
  end

endmodule

// File: rtl/sc_rowshifter_pingpong.sv
// sc_rowshifter_pingpong
// Owns one row of the LED-matrix game. The lit pattern moves one column
// per game tick, bouncing off the left and right edges; the registered
// row bus feeds the bottom-side comparators directly.
// Ports:
//   SC_ROWSHIFTER_CLOCK_50      - system clock, rising edge
//   SC_ROWSHIFTER_RESET_InHigh  - synchronous active-high reset
//   SC_ROWSHIFTER_load_In       - load data_InBUS into the row, go to HOLD
//   SC_ROWSHIFTER_data_InBUS    - pattern to load
//   SC_ROWSHIFTER_start_In      - start moving left (only from HOLD)
//   SC_ROWSHIFTER_stop_In       - freeze motion
//   SC_ROWSHIFTER_data_OutBUS   - registered row
//   SC_ROWSHIFTER_direction_Out - 1 while moving right
//   SC_ROWSHIFTER_moving_Out    - 1 while not in HOLD
//   SC_ROWSHIFTER_tick_Out      - 1-cycle pulse, high when the row updates
module sc_rowshifter_pingpong
  import sc_rowshifter_pkg::*;
#(
  parameter int ROWSHIFTER_DATAWIDTH = DEFAULT_DATAWIDTH,
  parameter int ROWSHIFTER_TICKDIV   = DEFAULT_TICKDIV,
  parameter int ROWSHIFTER_TICKWIDTH = DEFAULT_TICKWIDTH,
  parameter logic [ROWSHIFTER_DATAWIDTH-1:0] ROWSHIFTER_INITPATTERN =
    ROWSHIFTER_DATAWIDTH'(DEFAULT_INITPATTERN)
) (
  input  logic                            SC_ROWSHIFTER_CLOCK_50,
  input  logic                            SC_ROWSHIFTER_RESET_InHigh,
  input  logic                            SC_ROWSHIFTER_load_In,
  input  logic [ROWSHIFTER_DATAWIDTH-1:0] SC_ROWSHIFTER_data_InBUS,
  input  logic                            SC_ROWSHIFTER_start_In,
  input  logic                            SC_ROWSHIFTER_stop_In,
  output logic [ROWSHIFTER_DATAWIDTH-1:0] SC_ROWSHIFTER_data_OutBUS,
  output logic                            SC_ROWSHIFTER_direction_Out,
  output logic                            SC_ROWSHIFTER_moving_Out,
  output logic                            SC_ROWSHIFTER_tick_Out
);

  localparam int MSB = ROWSHIFTER_DATAWIDTH - 1;

  rowState_t                       state;
  logic [ROWSHIFTER_DATAWIDTH-1:0] row;
  logic                            tick;
  logic                            tickOut;
  logic                            rowEmpty;
  logic                            rowPinned;

  sc_tickprescaler #(
    .TICKDIV  (ROWSHIFTER_TICKDIV),
    .TICKWIDTH(ROWSHIFTER_TICKWIDTH)
  ) tickPrescaler (
    .clock   (SC_ROWSHIFTER_CLOCK_50),
    .reset   (SC_ROWSHIFTER_RESET_InHigh),
    .clear   (SC_ROWSHIFTER_load_In),
    .terminal(tick)
  );

  // An empty row, or one lit at both edges, has nowhere to go: shifting
  // it would either do nothing or make it bounce on every tick.
  assign rowEmpty  = (row == '0);
  assign rowPinned = row[MSB] && row[0];

  // Direction FSM and row register. Load beats stop, stop beats start,
  // and start only acts from HOLD; a tick is consumed only when none of
  // those fired. A bounce reverses direction and shifts back in the same
  // cycle, so the lit bit never sits on the edge for an extra tick.
  always_ff @(posedge SC_ROWSHIFTER_CLOCK_50) begin
    if (SC_ROWSHIFTER_RESET_InHigh) begin
      state   <= HOLD;
      row     <= ROWSHIFTER_INITPATTERN;
      tickOut <= 1'b0;
    end else begin
      tickOut <= tick;
      if (SC_ROWSHIFTER_load_In) begin
        state <= HOLD;
        row   <= SC_ROWSHIFTER_data_InBUS;
      end else if (SC_ROWSHIFTER_stop_In) begin
        state <= HOLD;
      end else if (SC_ROWSHIFTER_start_In && (state == HOLD)) begin
        state <= LEFT;
      end else if (tick && !rowEmpty && !rowPinned) begin
        case (state)
          LEFT: begin
            if (row[MSB]) begin
              state <= RIGHT;
              row   <= row >> 1;
            end else begin
              row <= row << 1;
            end
          end
          RIGHT: begin
            if (row[0]) begin
              state <= LEFT;
              row   <= row << 1;
            end else begin
              row <= row >> 1;
            end
          end
          default: begin
            row <= row;
          end
        endcase
      end
    end
  end

  assign SC_ROWSHIFTER_data_OutBUS   = row;
  assign SC_ROWSHIFTER_tick_Out      = tickOut;
  assign SC_ROWSHIFTER_direction_Out = (state == RIGHT);
  assign SC_ROWSHIFTER_moving_Out    = (state != HOLD);

endmodule

// File: tb/tb_sc_rowshifter_pingpong.sv
module tb_sc_rowshifter_pingpong;

  localparam int         DW    = 8;
  localparam int         TDIV  = 4;
  localparam int         TW    = 3;
  localparam logic [7:0] INITP = 8'b00000001;

  logic          clk = 1'b0;
  logic          reset;
  logic          load;
  logic          start;
  logic          stop;
  logic [DW-1:0] dataIn;
  logic [DW-1:0] rowOut;
  logic          dirOut;
  logic          movOut;
  logic          tickOut;

  // Reference model: row as a number, motion as two flags, prescaler as a
  // plain integer phase.
  logic [7:0] mRow;
  bit         mMoving;
  bit         mRight;
  bit         mTick;
  int         mCount;

  int testsRun;
  int testsFailed;

  always #5 clk = ~clk;

  sc_rowshifter_pingpong #(
    .ROWSHIFTER_DATAWIDTH  (DW),
    .ROWSHIFTER_TICKDIV    (TDIV),
    .ROWSHIFTER_TICKWIDTH  (TW),
    .ROWSHIFTER_INITPATTERN(INITP)
  ) dut (
    .SC_ROWSHIFTER_CLOCK_50     (clk),
    .SC_ROWSHIFTER_RESET_InHigh (reset),
    .SC_ROWSHIFTER_load_In      (load),
    .SC_ROWSHIFTER_data_InBUS   (dataIn),
    .SC_ROWSHIFTER_start_In     (start),
    .SC_ROWSHIFTER_stop_In      (stop),
    .SC_ROWSHIFTER_data_OutBUS  (rowOut),
    .SC_ROWSHIFTER_direction_Out(dirOut),
    .SC_ROWSHIFTER_moving_Out   (movOut),
    .SC_ROWSHIFTER_tick_Out     (tickOut)
  );

  // Compare every DUT output against the model.
  task automatic checkOutput(input string tag);
    testsRun++;
    assert (rowOut === mRow) else begin
      testsFailed++;
      $error("FAIL %s row: got %b expected %b", tag, rowOut, mRow);
    end
    testsRun++;
    assert (dirOut === mRight) else begin
      testsFailed++;
      $error("FAIL %s direction: got %b expected %b", tag, dirOut, mRight);
    end
    testsRun++;
    assert (movOut === mMoving) else begin
      testsFailed++;
      $error("FAIL %s moving: got %b expected %b", tag, movOut, mMoving);
    end
    testsRun++;
    assert (tickOut === mTick) else begin
      testsFailed++;
      $error("FAIL %s tick: got %b expected %b", tag, tickOut, mTick);
    end
  endtask

  // Compare one observed value against a fixed value derived by hand.
  task automatic checkValue(input string tag, input logic [7:0] observed,
                            input logic [7:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      testsFailed++;
      $error("FAIL %s: got %b expected %b", tag, observed, expected);
    end
  endtask

  // Drive one cycle of inputs, advance the model over the same edge, then
  // check the DUT 1 time unit after the edge.
  task automatic applyStimulus(input bit r, input bit ld, input bit st,
                               input bit sp, input logic [7:0] d,
                               input string tag);
    bit tickNow;
    bit litLeft;
    bit litRight;
    reset  = r;
    load   = ld;
    start  = st;
    stop   = sp;
    dataIn = d;
    @(posedge clk);
    if (r) begin
      mRow    = INITP;
      mMoving = 1'b0;
      mRight  = 1'b0;
      mCount  = 0;
      mTick   = 1'b0;
    end else begin
      tickNow = (mCount == TDIV - 1);
      mTick   = tickNow;
      mCount  = ld ? 0 : (mCount + 1) % TDIV;
      litLeft  = (mRow >= 8'd128);
      litRight = ((mRow % 8'd2) == 8'd1);
      if (ld) begin
        mRow    = d;
        mMoving = 1'b0;
        mRight  = 1'b0;
      end else if (sp) begin
        mMoving = 1'b0;
        mRight  = 1'b0;
      end else if (st && !mMoving) begin
        mMoving = 1'b1;
        mRight  = 1'b0;
      end else if (tickNow && mMoving && (mRow != 8'd0) && !(litLeft && litRight)) begin
        if (!mRight) begin
          if (litLeft) begin
            mRight = 1'b1;
            mRow   = mRow / 8'd2;
          end else begin
            mRow = mRow * 8'd2;
          end
        end else begin
          if (litRight) begin
            mRight = 1'b0;
            mRow   = mRow * 8'd2;
          end else begin
            mRow = mRow / 8'd2;
          end
        end
      end
    end
    #1;
    checkOutput(tag);
  endtask

  initial begin
    logic [7:0] frozenRow;
    bit         sawBottomLeft;
    testsRun      = 0;
    testsFailed   = 0;
    sawBottomLeft = 1'b0;
    reset  = 1'b1;
    load   = 1'b0;
    start  = 1'b0;
    stop   = 1'b0;
    dataIn = 8'd0;

    // Reset for two cycles, then idle without start.
    applyStimulus(1, 0, 0, 0, 8'd0, "reset");
    applyStimulus(1, 0, 0, 0, 8'd0, "reset");
    checkValue("resetRow", rowOut, INITP);
    for (int i = 0; i < 20; i++) applyStimulus(0, 0, 0, 0, 8'd0, "idleHold");
    checkValue("holdRow", rowOut, INITP);

    // Start and let the pattern walk left, bounce, walk right, bounce.
    applyStimulus(0, 0, 1, 0, 8'd0, "start");
    for (int i = 0; i < 80; i++) begin
      applyStimulus(0, 0, 0, 0, 8'd0, "walk");
      if (rowOut == 8'b00001000) sawBottomLeft = 1'b1;
    end
    checkValue("bottomLeftSeen", 8'(sawBottomLeft), 8'd1);

    // Load zero while moving, then start: an empty row never bounces.
    applyStimulus(0, 1, 0, 0, 8'h00, "loadZero");
    applyStimulus(0, 0, 1, 0, 8'h00, "startZero");
    for (int i = 0; i < 14; i++) applyStimulus(0, 0, 0, 0, 8'd0, "zeroRow");
    checkValue("zeroRow", rowOut, 8'h00);
    checkValue("zeroMoving", 8'(movOut), 8'd1);

    // Both edges lit: the row is pinned and stays LEFT.
    applyStimulus(0, 1, 0, 0, 8'h81, "loadPinned");
    applyStimulus(0, 0, 1, 0, 8'h00, "startPinned");
    for (int i = 0; i < 22; i++) applyStimulus(0, 0, 0, 0, 8'd0, "pinnedRow");
    checkValue("pinnedRow", rowOut, 8'h81);
    checkValue("pinnedDir", 8'(dirOut), 8'd0);
    checkValue("pinnedMoving", 8'(movOut), 8'd1);

    // Stop coinciding with the terminal count: no shift, motion frozen.
    applyStimulus(0, 1, 0, 0, 8'b00010000, "loadMid");
    applyStimulus(0, 0, 1, 0, 8'h00, "startMid");
    for (int i = 0; i < 6; i++) applyStimulus(0, 0, 0, 0, 8'd0, "midWalk");
    for (int i = 0; i < TDIV && mCount != TDIV - 1; i++)
      applyStimulus(0, 0, 0, 0, 8'd0, "alignTick");
    frozenRow = rowOut;
    applyStimulus(0, 0, 0, 1, 8'h00, "stopOnTick");
    checkValue("stopRow", rowOut, frozenRow);
    checkValue("stopMoving", 8'(movOut), 8'd0);
    checkValue("stopTickPulse", 8'(tickOut), 8'd1);

    // Reset in the middle of motion.
    applyStimulus(0, 0, 1, 0, 8'h00, "restart");
    for (int i = 0; i < 7; i++) applyStimulus(0, 0, 0, 0, 8'd0, "preReset");
    applyStimulus(1, 0, 0, 0, 8'h00, "midReset");
    checkValue("midResetRow", rowOut, INITP);
    checkValue("midResetMoving", 8'(movOut), 8'd0);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      bit         r;
      bit         ld;
      bit         st;
      bit         sp;
      logic [7:0] d;
      r  = ($urandom_range(0, 99) == 0);
      ld = ($urandom_range(0, 29) == 0);
      st = ($urandom_range(0, 9) == 0);
      sp = ($urandom_range(0, 39) == 0);
      case ($urandom_range(0, 3))
        0:       d = 8'd1 << $urandom_range(0, 7);
        1:       d = 8'h81;
        2:       d = 8'h00;
        default: d = 8'($urandom);
      endcase
      applyStimulus(r, ld, st, sp, d, "random");
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/sc_rowshifter_pingpong.md
Name: sc_rowshifter_pingpong

Overview:
- Upstream stage of the bottom-side comparators: owns one 8-bit row of the LED-matrix game.
- Moves the lit pattern one column per game tick, bouncing off the left and right edges.
- Its registered row bus drives the comparator data inputs directly, e.g. the bottom-side-left "== 8'b00001000" check.
- Includes its own tick prescaler, a 3-state direction FSM and a synchronous load path.

Parameters:
- ROWSHIFTER_DATAWIDTH, 8, row width in bits.
- ROWSHIFTER_TICKDIV, 25000000, clock cycles per game tick; must be >= 2.
- ROWSHIFTER_TICKWIDTH, 25, prescaler counter width; must satisfy 2^W >= TICKDIV.
- ROWSHIFTER_INITPATTERN, 8'b00000001, row value after reset.

Ports:
- SC_ROWSHIFTER_CLOCK_50  in  1  system clock, all logic rising-edge.
- SC_ROWSHIFTER_RESET_InHigh  in  1  synchronous, active-high reset.
- SC_ROWSHIFTER_load_In  in  1  1-cycle pulse: load data_InBUS into the row.
- SC_ROWSHIFTER_data_InBUS  in  DATAWIDTH  pattern to load.
- SC_ROWSHIFTER_start_In  in  1  level/pulse: begin moving left (from HOLD only).
- SC_ROWSHIFTER_stop_In  in  1  pulse: freeze motion.
- SC_ROWSHIFTER_data_OutBUS  out  DATAWIDTH  registered row, feeds the comparators.
- SC_ROWSHIFTER_direction_Out  out  1  1 = moving right, 0 = left or hold.
- SC_ROWSHIFTER_moving_Out  out  1  1 when state != HOLD.
- SC_ROWSHIFTER_tick_Out  out  1  registered 1-cycle pulse marking each row update opportunity.

Behaviour:
- Clock and reset: one clock, SC_ROWSHIFTER_CLOCK_50. Reset SC_ROWSHIFTER_RESET_InHigh is synchronous and active-high; it is sampled only on the rising clock edge and has top priority.
- Reset values: row = INITPATTERN; state = HOLD; prescaler = 0; tick_Out = 0; direction_Out = 0; moving_Out = 0.
- Prescaler:
  - Counts 0..TICKDIV-1 and wraps to 0.
  - An internal tick is asserted in the cycle the count equals TICKDIV-1.
  - tick_Out is that tick registered: it goes high the cycle after the terminal count, for exactly 1 cycle.
  - The prescaler is cleared to 0 on load.
- FSM states: HOLD, LEFT, RIGHT.
  - HOLD: start_In -> LEFT. Ticks are ignored and the row is unchanged.
  - LEFT, on tick:
    - if row[MSB]=0, row <= row << 1 (zero-fill);
    - if row[MSB]=1, state <= RIGHT and row <= row >> 1 in the same cycle (the bounce consumes the tick).
  - RIGHT, on tick: mirror image, using row[0] and a shift right, reversing to LEFT.
  - Any state: stop_In -> HOLD with the row unchanged.
- Priority per cycle: reset > load > stop > start > tick.
  - Load forces HOLD, row <= data_InBUS, prescaler <= 0.
  - Start while already LEFT or RIGHT is ignored.
- Boundary rules:
  - Row all zeros: shift on tick is a no-op, state unchanged, no bounce.
  - Row[MSB] and row[0] both 1: row unchanged on tick, state unchanged (no oscillation).
  - Tick coincident with stop or load: stop/load wins and no shift occurs.
  - Reset mid-motion: next cycle shows INITPATTERN, HOLD, prescaler 0.
- Latency:
  - data_OutBUS updates 1 cycle after the terminal-count cycle, in the same cycle tick_Out is high.
  - A load is visible on data_OutBUS the cycle after load_In.
- Width rules:
  - Shifts are logical within DATAWIDTH; no wrap-around of bits.
  - The prescaler compare uses TICKWIDTH bits.
- Outputs: moving_Out and direction_Out are decoded from the state register (registered, glitch-free).

Decomposition:
- Shared package sc_rowshifter_pkg:
  - state encoding constants HOLD=2'b00, LEFT=2'b01, RIGHT=2'b10;
  - default TICKDIV and INITPATTERN constants, so the comparators and the game FSM share the same widths.
- One natural sub-module, sc_tickprescaler: counter with synchronous clear, synchronous reset and a terminal-count pulse.
- The FSM and row register stay in the top module.

Test Plan (TICKDIV=4, DATAWIDTH=8):
1. Reset held for 2 cycles, then released -> data_OutBUS=8'b00000001, moving_Out=0; no change after 20 cycles without start.
2. start_In pulse from reset -> tick_Out every 4 cycles; row goes 00000010, 00000100, 00001000 (bottom-left comparator must see a 1 exactly there), …, 10000000; the next tick gives 01000000 with direction_Out=1.
3. Moving right at 00000010, two ticks -> 00000001, then 00000010 with direction_Out=0.
4. load_In with data 8'b00000000 while moving -> HOLD, row=0; then start_In plus 3 ticks -> row stays 0, no bounce.
5. load_In with 8'b10000001, then start_In -> row unchanged over 5 ticks, state stays LEFT.
6. stop_In asserted in the same cycle as the terminal count -> no shift, moving_Out=0 next cycle. Then reset asserted mid-motion -> INITPATTERN and HOLD on the next edge.
